queue_write_arbiter: RTL and testbench

Round-robin write-side controller that shares one circular queue between `NREQ` producers, e.g. multiple dispatch or writeback lanes feeding a single in-order queue in the OoO core. Each cycle it grants at most one valid requester and drives the queue's write port. It tracks queue occupancy with its own counter, so the queue is never written when full and never popped when empty. A flush input clears occupancy and the arbitration pointer and asserts a clear to the queue.

---
 rtl/queue_arb_pkg.sv | 27 ++
 rtl/rr_pick.sv | 53 +++++
 rtl/queue_write_arbiter.sv | 77 +++++++
 tb/tb_queue_write_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/queue_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : queue_arb_pkg
// Brief    : Shared widths and index type for the queue write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package queue_arb_pkg;

  localparam int c_nreq_default  = 4;
  localparam int c_depth_default = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One extra bit so that count can hold DEPTH itself.
  function automatic int cnt_width(input int d);
    return $clog2(d) + 1;
  endfunction

  localparam int c_arb_idx_w = idx_width(c_nreq_default);
  localparam int c_arb_cnt_w = cnt_width(c_depth_default);

  typedef logic [c_arb_idx_w-1:0] arb_idx_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker (double-width rotate + find-first).
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import queue_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]            req,
  input  logic [idx_width(NREQ)-1:0] rr_ptr,
  output logic [NREQ-1:0]            grant,
  output logic [idx_width(NREQ)-1:0] winner,
  output logic                       any
);

  localparam int c_idx_w = idx_width(NREQ);

  logic [2*NREQ-1:0] w_dbl;
  logic [2*NREQ-1:0] w_shift;
  logic [NREQ-1:0]   w_rot;
  logic [c_idx_w-1:0] w_off;
  logic [c_idx_w:0]   w_sum;

  // Rotating the doubled vector puts rr_ptr at bit 0, so the lowest set bit
  // is the first requester in round-robin order.
  assign w_dbl   = {req, req};
  assign w_shift = w_dbl >> rr_ptr;
  assign w_rot   = w_shift[NREQ-1:0];
  assign any     = |req;

  always_comb begin
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = c_idx_w'(i);
    end
  end

  assign w_sum = {1'b0, rr_ptr} + {1'b0, w_off};

  always_comb begin
    if (w_sum >= (c_idx_w+1)'(NREQ)) begin
      winner = c_idx_w'(w_sum - (c_idx_w+1)'(NREQ));
    end else begin
      winner = w_sum[c_idx_w-1:0];
    end
    grant = any ? (NREQ'(1) << winner) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/queue_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : queue_write_arbiter
// Brief    : Round-robin write controller sharing one circular queue among NREQ producers.
// Revision : 1.0 - initial release
// ============================================================================
module queue_write_arbiter
  import queue_arb_pkg::*;
#(
  parameter type T     = logic [31:0],
  parameter int  NREQ  = 4,
  parameter int  DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NREQ-1:0]             req_valid,
  input  T     [NREQ-1:0]             req_data,
  output logic [NREQ-1:0]             req_ready,
  output logic                        q_write_en,
  output T                            q_write_data,
  output logic                        q_clear,
  input  logic                        deq_en,
  output logic                        q_read_en,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic [idx_width(NREQ)-1:0]  grant_id
);

  localparam int c_idx_w = idx_width(NREQ);
  localparam int c_cnt_w = cnt_width(DEPTH);

  logic [c_idx_w-1:0] r_rr_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic [NREQ-1:0]    w_pick_grant;
  logic [c_idx_w-1:0] w_winner;
  logic [c_idx_w-1:0] w_next_ptr;
  logic               w_any;
  logic               w_space;
  logic               w_grant;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req    (req_valid),
    .rr_ptr (r_rr_ptr),
    .grant  (w_pick_grant),
    .winner (w_winner),
    .any    (w_any)
  );

  // A same-cycle pop does not free a slot; space is judged on registered count.
  assign w_space = (r_count < c_cnt_w'(DEPTH));
  assign w_grant = w_any && w_space && !flush && !reset;

  assign req_ready    = w_grant ? w_pick_grant : '0;
  assign q_write_en   = w_grant;
  assign q_write_data = req_data[w_winner];
  assign grant_id     = w_grant ? w_winner : '0;
  assign q_clear      = reset || flush;
  assign q_read_en    = deq_en && (r_count != '0) && !flush && !reset;
  assign count        = r_count;

  assign w_next_ptr = (w_winner == c_idx_w'(NREQ - 1)) ? '0 : w_winner + c_idx_w'(1);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_count  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_count <= r_count + c_cnt_w'(q_write_en) - c_cnt_w'(q_read_en);
      if (w_grant) r_rr_ptr <= w_next_ptr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_queue_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_queue_write_arbiter
// Brief    : Directed self-checking bench for queue_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_queue_write_arbiter;

  logic             clk;
  logic             reset;
  logic             flush;
  logic [3:0]       req_valid;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_ready;
  logic             q_write_en;
  logic [31:0]      q_write_data;
  logic             q_clear;
  logic             deq_en;
  logic             q_read_en;
  logic [3:0]       count;
  logic [1:0]       grant_id;

  int checks;
  int failures;

  queue_write_arbiter #(
    .T     (logic [31:0]),
    .NREQ  (4),
    .DEPTH (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .q_write_en   (q_write_en),
    .q_write_data (q_write_data),
    .q_clear      (q_clear),
    .deq_en       (deq_en),
    .q_read_en    (q_read_en),
    .count        (count),
    .grant_id     (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_data();
    for (int k = 0; k < 4; k++) req_data[k] = 32'hD000_0000 | k;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; req_valid = '0; deq_en = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; req_valid = 4'b1111; deq_en = 1'b1; set_data();
    step(); settle();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
    checks++; if (q_write_en !== 1'b0) begin failures++; $display("FAIL rst_wen got=%b exp=0", q_write_en); end
    checks++; if (q_read_en !== 1'b0) begin failures++; $display("FAIL rst_ren got=%b exp=0", q_read_en); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rst_gid got=%0d exp=0", grant_id); end
    checks++; if (q_clear !== 1'b1) begin failures++; $display("FAIL rst_clear got=%b exp=1", q_clear); end
    step();
    reset = 1'b0; req_valid = '0; deq_en = 1'b0;
    settle();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (q_clear !== 1'b0) begin failures++; $display("FAIL rst_clear_off got=%b exp=0", q_clear); end
    // Reset in the middle of operation
    req_valid = 4'b1111;
    step(); step();
    reset = 1'b1;
    settle();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL midrst_ready got=%b exp=0000", req_ready); end
    step();
    reset = 1'b0; req_valid = '0;
    settle();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", count); end
  endtask

  task automatic test_basic_grant();
    do_reset();
    req_valid = 4'b0100; req_data[2] = 32'h0000_00A5;
    settle();
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL basic_ready got=%b exp=0100", req_ready); end
    checks++; if (q_write_en !== 1'b1) begin failures++; $display("FAIL basic_wen got=%b exp=1", q_write_en); end
    checks++; if (q_write_data !== 32'h0000_00A5) begin failures++; $display("FAIL basic_wdata got=%h exp=000000a5", q_write_data); end
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL basic_gid got=%0d exp=2", grant_id); end
    step();
    // rr_ptr should now be 3: with everyone requesting, requester 3 wins
    req_valid = 4'b1111; set_data();
    settle();
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", count); end
    checks++; if (grant_id !== 2'd3) begin failures++; $display("FAIL basic_ptr got=%0d exp=3", grant_id); end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ready;
    do_reset();
    set_data();
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      settle();
      exp_ready = 4'b0001 << (i % 4);
      checks++; if (grant_id !== 2'(i % 4)) begin failures++; $display("FAIL rr_gid[%0d] got=%0d exp=%0d", i, grant_id, i % 4); end
      checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, req_ready, exp_ready); end
      checks++; if (q_write_data !== (32'hD000_0000 | (i % 4))) begin failures++; $display("FAIL rr_wdata[%0d] got=%h exp=%h", i, q_write_data, 32'hD000_0000 | (i % 4)); end
      step();
    end
    settle();
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL rr_count got=%0d exp=8", count); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rr_full_ready got=%b exp=0000", req_ready); end
    checks++; if (q_write_en !== 1'b0) begin failures++; $display("FAIL rr_full_wen got=%b exp=0", q_write_en); end
  endtask

  // Continues from the full queue left by test_round_robin (count=8, ptr=0).
  task automatic test_full_boundary();
    req_valid = 4'b1111; deq_en = 1'b1;
    settle();
    checks++; if (q_read_en !== 1'b1) begin failures++; $display("FAIL full_ren got=%b exp=1", q_read_en); end
    checks++; if (q_write_en !== 1'b0) begin failures++; $display("FAIL full_wen got=%b exp=0", q_write_en); end
    step();
    deq_en = 1'b0;
    settle();
    checks++; if (count !== 4'd7) begin failures++; $display("FAIL full_count got=%0d exp=7", count); end
    checks++; if (q_write_en !== 1'b1) begin failures++; $display("FAIL full_regrant got=%b exp=1", q_write_en); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL full_gid got=%0d exp=0", grant_id); end
    step();
    req_valid = '0;
    settle();
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL full_refill got=%0d exp=8", count); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_data();
    req_valid = 4'b1111;
    step(); step(); step();
    req_valid = 4'b0010; deq_en = 1'b1;
    settle();
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL sim_pre_count got=%0d exp=3", count); end
    checks++; if (q_read_en !== 1'b1 || q_write_en !== 1'b1) begin failures++; $display("FAIL sim_strobes got=%b%b exp=11", q_read_en, q_write_en); end
    checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL sim_gid got=%0d exp=1", grant_id); end
    step();
    deq_en = 1'b0; req_valid = 4'b1111;
    settle();
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL sim_count got=%0d exp=3", count); end
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL sim_ptr got=%0d exp=2", grant_id); end
    req_valid = '0;
  endtask

  task automatic test_empty_pop();
    do_reset();
    deq_en = 1'b1;
    settle();
    checks++; if (q_read_en !== 1'b0) begin failures++; $display("FAIL empty_ren got=%b exp=0", q_read_en); end
    step();
    settle();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL empty_count got=%0d exp=0", count); end
    deq_en = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    set_data();
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) step();
    req_valid = '0; deq_en = 1'b1;
    step();
    // count=5, rr_ptr=2
    req_valid = 4'b1111; flush = 1'b1;
    settle();
    checks++; if (count !== 4'd5) begin failures++; $display("FAIL flush_pre_count got=%0d exp=5", count); end
    checks++; if (q_write_en !== 1'b0 || req_ready !== 4'b0000) begin failures++; $display("FAIL flush_grant got=%b/%b exp=0/0000", q_write_en, req_ready); end
    checks++; if (q_clear !== 1'b1) begin failures++; $display("FAIL flush_clear got=%b exp=1", q_clear); end
    checks++; if (q_read_en !== 1'b0) begin failures++; $display("FAIL flush_ren got=%b exp=0", q_read_en); end
    step();
    flush = 1'b0; deq_en = 1'b0;
    settle();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (q_write_en !== 1'b1 || grant_id !== 2'd0) begin failures++; $display("FAIL flush_first got=%b/%0d exp=1/0", q_write_en, grant_id); end
    checks++; if (q_clear !== 1'b0) begin failures++; $display("FAIL flush_clear_off got=%b exp=0", q_clear); end
    step();
    req_valid = '0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; flush = 1'b0; req_valid = '0; deq_en = 1'b0; req_data = '0;
    test_reset();
    test_basic_grant();
    test_round_robin();
    test_full_boundary();
    test_simultaneous();
    test_empty_pop();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
